// File: rtl/wf_pkg.sv
// wf_pkg: shared definitions for the waveform memory loader.
//   - wf_state_t     : loader FSM states
//   - DEF_ADDR_W/DATA_W : default RAM geometry
//   - effective_len  : maps a programmed length of 0 to full RAM depth
package wf_pkg;

    localparam int unsigned DEF_ADDR_W = 14;
    localparam int unsigned DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        WRITE   = 2'd2
    } wf_state_t;

    // A programmed length of 0 selects the whole RAM (2^addr_w words).
    function automatic logic [31:0] effective_len(input logic [31:0] len,
                                                  input int unsigned addr_w);
        if (len == '0) begin
            return 32'd1 << addr_w;
        end
        return len;
    endfunction

endpackage

// File: rtl/wf_mem_loader_sync_edge.sv
// sync_edge: multi-flop synchroniser for an asynchronous level, plus a
// registered copy of the synchronised value for rising-edge detection.
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous input level
//   level      : synchronised level
//   rise       : one-cycle pulse when level goes 0 -> 1
module sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/wf_mem_loader.sv
// wf_mem_loader: brings the FX2 waveform write strobe into the system clock
// domain and writes each strobed word into the waveform RAM at an
// auto-incrementing address.
//   clk, rst_n          : system/RAM clock, async active-low reset
//   wf_mem_data         : quasi-static waveform word from the FX2 register bank
//   wf_mem_clk          : asynchronous write strobe (rising edge = new word)
//   load_en, addr_clr   : asynchronous control levels (enable / clear)
//   wf_len              : words to load, 0 = full depth
//   ram_we/addr/wdata   : RAM write port
//   wr_count            : words written since last clear
//   busy, done, overrun : status back to the control path
module wf_mem_loader
    import wf_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wf_mem_data,
    input  logic              wf_mem_clk,
    input  logic              load_en,
    input  logic              addr_clr,
    input  logic [ADDR_W-1:0] wf_len,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W:0]   wr_count,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    wf_state_t state, state_nxt;

    logic strb_rise, strb_lvl;
    logic load_lvl, clr_lvl;
    logic cap_en, wr_done, ovr_set;

    logic [31:0]     eff_len32;
    logic [ADDR_W:0] eff_len;
    logic [ADDR_W:0] count_nxt;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_strb (
        .clk(clk), .rst_n(rst_n), .d(wf_mem_clk), .level(strb_lvl), .rise(strb_rise)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
        .clk(clk), .rst_n(rst_n), .d(load_en), .level(load_lvl), .rise()
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clr (
        .clk(clk), .rst_n(rst_n), .d(addr_clr), .level(clr_lvl), .rise()
    );

    assign eff_len32 = effective_len(32'(wf_len), ADDR_W);
    assign eff_len   = eff_len32[ADDR_W:0];
    assign count_nxt = wr_count + (ADDR_W+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cap_en    = 1'b0;
        wr_done   = 1'b0;
        ovr_set   = 1'b0;
        if (clr_lvl) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // With loading disabled an edge is silently ignored.
                    if (strb_rise && load_lvl) begin
                        if (done) begin
                            ovr_set = 1'b1;
                        end else begin
                            state_nxt = CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    cap_en    = 1'b1;
                    state_nxt = WRITE;
                    ovr_set   = strb_rise;
                end
                WRITE: begin
                    wr_done   = 1'b1;
                    state_nxt = IDLE;
                    ovr_set   = strb_rise;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Combinational from state so an async reset or a clear removes the
    // pulse in the same cycle.
    assign ram_we   = (state == WRITE) && !clr_lvl;
    assign ram_addr = wr_count[ADDR_W-1:0];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_wdata <= '0;
            wr_count  <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else if (clr_lvl) begin
            wr_count <= '0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (cap_en) begin
                ram_wdata <= wf_mem_data;
            end
            if (wr_done) begin
                wr_count <= count_nxt;
                // >= so a length shrunk below the current count still
                // completes on the next write.
                if (count_nxt >= eff_len) begin
                    done <= 1'b1;
                end
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wf_mem_loader.sv
// tb_wf_mem_loader: directed self-checking bench for wf_mem_loader
// (ADDR_W=4 so full-depth wrap is reachable in a short run).
module tb_wf_mem_loader;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 16;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] wf_mem_data;
    logic          wf_mem_clk;
    logic          load_en;
    logic          addr_clr;
    logic [AW-1:0] wf_len;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [AW:0]   wr_count;
    logic          busy;
    logic          done;
    logic          overrun;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] we_addr[$];
    logic [DW-1:0] we_data[$];

    wf_mem_loader #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .wf_mem_data(wf_mem_data), .wf_mem_clk(wf_mem_clk),
        .load_en(load_en), .addr_clr(addr_clr), .wf_len(wf_len),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .wr_count(wr_count), .busy(busy), .done(done), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every RAM write seen at the falling edge.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            we_addr.push_back(ram_addr);
            we_data.push_back(ram_wdata);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [DW-1:0] d);
        wf_mem_data = d;
        wf_mem_clk  = 1'b1;
        tick(2);
        wf_mem_clk  = 1'b0;
        tick(4);
    endtask

    task automatic clear_all();
        addr_clr = 1'b1;
        tick(3);
        addr_clr = 1'b0;
        tick(3);
    endtask

    task automatic flush_log();
        we_addr.delete();
        we_data.delete();
    endtask

    initial begin
        rst_n       = 1'b0;
        wf_mem_data = '0;
        wf_mem_clk  = 1'b0;
        load_en     = 1'b1;
        addr_clr    = 1'b0;
        wf_len      = 4'd4;

        // Reset values
        tick(3);
        check("rst_ram_we",    32'(ram_we),    32'd0);
        check("rst_ram_addr",  32'(ram_addr),  32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_wr_count",  32'(wr_count),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);
        rst_n = 1'b1;
        tick(3);

        // Four words, length 4
        flush_log();
        strobe(16'h1111);
        strobe(16'h2222);
        strobe(16'h3333);
        strobe(16'h4444);
        check("len4_nwrites", 32'(we_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("len4_addr%0d", i), 32'(we_addr[i]), 32'(i));
            check($sformatf("len4_data%0d", i), 32'(we_data[i]), 32'(16'h1111 * (i + 1)));
        end
        check("len4_wr_count", 32'(wr_count), 32'd4);
        check("len4_ram_addr", 32'(ram_addr), 32'd4);
        check("len4_done",     32'(done),     32'd1);
        check("len4_overrun",  32'(overrun),  32'd0);
        check("len4_busy",     32'(busy),     32'd0);

        // Strobe with loading disabled
        clear_all();
        load_en = 1'b0;
        tick(3);
        flush_log();
        strobe(16'h5555);
        check("dis_nwrites",  32'(we_addr.size()), 32'd0);
        check("dis_wr_count", 32'(wr_count),       32'd0);
        check("dis_overrun",  32'(overrun),        32'd0);
        check("dis_done",     32'(done),           32'd0);

        // Length 2, three strobes
        load_en = 1'b1;
        wf_len  = 4'd2;
        tick(3);
        flush_log();
        strobe(16'hAAAA);
        strobe(16'hBBBB);
        strobe(16'hCCCC);
        check("len2_nwrites",  32'(we_addr.size()), 32'd2);
        check("len2_addr0",    32'(we_addr[0]),     32'd0);
        check("len2_data0",    32'(we_data[0]),     32'hAAAA);
        check("len2_addr1",    32'(we_addr[1]),     32'd1);
        check("len2_data1",    32'(we_data[1]),     32'hBBBB);
        check("len2_wr_count", 32'(wr_count),       32'd2);
        check("len2_done",     32'(done),           32'd1);
        check("len2_overrun",  32'(overrun),        32'd1);

        // Back-to-back edges: the second edge is detected while the first
        // word is in WRITE and must be dropped.
        clear_all();
        wf_len = 4'd4;
        flush_log();
        wf_mem_data = 16'h1234;
        wf_mem_clk  = 1'b1;
        tick(1);
        wf_mem_clk  = 1'b0;
        tick(1);
        wf_mem_clk  = 1'b1;
        tick(1);
        wf_mem_clk  = 1'b0;
        tick(6);
        check("b2b_nwrites",  32'(we_addr.size()), 32'd1);
        check("b2b_addr0",    32'(we_addr[0]),     32'd0);
        check("b2b_data0",    32'(we_data[0]),     32'h1234);
        check("b2b_wr_count", 32'(wr_count),       32'd1);
        check("b2b_overrun",  32'(overrun),        32'd1);
        check("b2b_done",     32'(done),           32'd0);

        // Clear landing while the word is in CAPTURE
        flush_log();
        wf_mem_data = 16'h7777;
        wf_mem_clk  = 1'b1;
        tick(1);
        addr_clr    = 1'b1;
        tick(2);
        addr_clr    = 1'b0;
        tick(1);
        wf_mem_clk  = 1'b0;
        tick(5);
        check("clr_nwrites",  32'(we_addr.size()), 32'd0);
        check("clr_wr_count", 32'(wr_count),       32'd0);
        check("clr_overrun",  32'(overrun),        32'd0);
        check("clr_done",     32'(done),           32'd0);
        check("clr_busy",     32'(busy),           32'd0);
        strobe(16'h8888);
        check("clr_next_nwrites",  32'(we_addr.size()), 32'd1);
        check("clr_next_addr",     32'(we_addr[0]),     32'd0);
        check("clr_next_data",     32'(we_data[0]),     32'h8888);
        check("clr_next_wr_count", 32'(wr_count),       32'd1);

        // Full depth (wf_len = 0) and wrap
        clear_all();
        wf_len = 4'd0;
        tick(1);
        flush_log();
        for (int i = 0; i < 16; i++) begin
            strobe(16'(16'h0100 + i));
        end
        check("full_nwrites", 32'(we_addr.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("full_addr%0d", i), 32'(we_addr[i]), 32'(i));
            check($sformatf("full_data%0d", i), 32'(we_data[i]), 32'(16'h0100 + i));
        end
        check("full_wr_count", 32'(wr_count), 32'd16);
        check("full_ram_addr", 32'(ram_addr), 32'd0);
        check("full_done",     32'(done),     32'd1);
        check("full_overrun0", 32'(overrun),  32'd0);
        strobe(16'hDEAD);
        check("full_overrun1",  32'(overrun),        32'd1);
        check("full_nwrites17", 32'(we_addr.size()), 32'd16);
        check("full_wr_count2", 32'(wr_count),       32'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
